tx_sweep_ctrl: RTL and testbench

//  Sequencer for the transmit path: drives pattern select (PRBS-7/PRBS-13) and signed pre-emphasis taps.
//  On start it walks every enabled pattern across the tap range TAP_MIN..TAP_MAX.
//  For each setting it waits for the path to settle, then opens a measurement window.
//  It counts receiver-checker errors and reports one result per setting.

---
 rtl/tx_pkg.sv | 17 +
 rtl/tx_sweep_timer.sv | 29 ++
 rtl/tx_sweep_ctrl.sv | 177 +++++++++++++++++
 tb/tb_tx_sweep_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared transmit-path definitions: sweep FSM states, pattern codes and tap width.
package tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StDwell,
        StReport,
        StFin
    } sweep_state_e;

    localparam logic PAT_PRBS7  = 1'b0;
    localparam logic PAT_PRBS13 = 1'b1;

    localparam int unsigned TAP_W = 3;

endpackage

// File: rtl/tx_sweep_timer.sv
// Loadable down-counter with zero flag; paces both the settle and the dwell intervals.
module tx_sweep_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tx_sweep_ctrl.sv
// Transmit sweep sequencer: steps pattern and signed taps, settles, measures errors per setting.
module tx_sweep_ctrl
    import tx_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned CW         = 24,
    parameter int          TAP_MIN    = -4,
    parameter int          TAP_MAX    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       pat_mask,
    input  logic [DW-1:0]    dwell_len,
    input  logic             err_in,
    output logic             control,
    output logic [TAP_W-1:0] taps,
    output logic             meas_en,
    output logic             busy,
    output logic             res_valid,
    output logic             res_pattern,
    output logic [TAP_W-1:0] res_taps,
    output logic [CW-1:0]    res_errs,
    output logic             done
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TW = (DW > SW) ? DW : SW;
    localparam logic [TW-1:0] SettleM1 = TW'(SETTLE_CYC - 1);
    localparam logic signed [TAP_W-1:0] TapMin = TAP_W'(TAP_MIN);
    localparam logic signed [TAP_W-1:0] TapMax = TAP_W'(TAP_MAX);

    sweep_state_e  state_q;
    logic [1:0]    mask_q;
    logic [TW-1:0] dwell_q;
    logic [TW-1:0] dwell_m1;
    logic [CW-1:0] err_cnt_q;
    logic [CW-1:0] err_next;
    logic          last_tap;
    logic          has_next;
    logic          tmr_load;
    logic          tmr_zero;
    logic [TW-1:0] tmr_val;

    // Timer holds (window length - 1); a zero dwell still measures one cycle.
    assign dwell_m1 = (dwell_len == '0) ? '0 : TW'(dwell_len - DW'(1));
    assign last_tap = ($signed(taps) >= TapMax);
    assign has_next = (control == PAT_PRBS7) && mask_q[1];

    always_comb begin
        err_next = err_cnt_q;
        if (meas_en && err_in && (err_cnt_q != {CW{1'b1}})) begin
            err_next = err_cnt_q + CW'(1);
        end
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            StIdle: begin
                if (start && (pat_mask != 2'b00)) begin
                    tmr_load = 1'b1;
                    tmr_val  = SettleM1;
                end
            end
            StSettle: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = dwell_q;
                end
            end
            StReport: begin
                if (!last_tap || has_next) begin
                    tmr_load = 1'b1;
                    tmr_val  = SettleM1;
                end
            end
            default: ;
        endcase
    end

    tx_sweep_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (abort),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            mask_q      <= 2'b00;
            dwell_q     <= '0;
            err_cnt_q   <= '0;
            control     <= PAT_PRBS7;
            taps        <= '0;
            meas_en     <= 1'b0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_pattern <= 1'b0;
            res_taps    <= '0;
            res_errs    <= '0;
            done        <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            if (abort) begin
                state_q   <= StIdle;
                meas_en   <= 1'b0;
                busy      <= 1'b0;
                err_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            busy <= 1'b1;
                            if (pat_mask == 2'b00) begin
                                state_q <= StFin;
                                done    <= 1'b1;
                            end else begin
                                mask_q  <= pat_mask;
                                dwell_q <= dwell_m1;
                                control <= pat_mask[0] ? PAT_PRBS7 : PAT_PRBS13;
                                taps    <= TapMin;
                                state_q <= StSettle;
                            end
                        end
                    end
                    StSettle: begin
                        if (tmr_zero) begin
                            state_q   <= StDwell;
                            meas_en   <= 1'b1;
                            err_cnt_q <= '0;
                        end
                    end
                    StDwell: begin
                        err_cnt_q <= err_next;
                        if (tmr_zero) begin
                            state_q     <= StReport;
                            meas_en     <= 1'b0;
                            res_valid   <= 1'b1;
                            res_pattern <= control;
                            res_taps    <= taps;
                            res_errs    <= err_next;
                        end
                    end
                    StReport: begin
                        if (!last_tap) begin
                            taps    <= taps + TAP_W'(1);
                            state_q <= StSettle;
                        end else if (has_next) begin
                            taps    <= TapMin;
                            control <= PAT_PRBS13;
                            state_q <= StSettle;
                        end else begin
                            state_q <= StFin;
                            done    <= 1'b1;
                        end
                    end
                    StFin: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_sweep_ctrl.sv
// Randomized bench for tx_sweep_ctrl against a schedule-based model of the sweep.
module tb_tx_sweep_ctrl;

    localparam int unsigned S      = 2;
    localparam int unsigned DW     = 16;
    localparam int unsigned CW     = 4;
    localparam int          TMIN   = -4;
    localparam int          TMAX   = 3;
    localparam int          MaxErr = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    pat_mask = 2'b00;
    logic [DW-1:0] dwell_len = '0;
    logic          err_in = 1'b0;
    logic          control;
    logic [2:0]    taps;
    logic          meas_en;
    logic          busy;
    logic          res_valid;
    logic          res_pattern;
    logic [2:0]    res_taps;
    logic [CW-1:0] res_errs;
    logic          done;

    int n_cmp = 0;
    int n_bad = 0;

    // Model-side view of held outputs.
    int exp_ctrl = 0;
    int exp_taps = 0;
    int exp_rp   = 0;
    int exp_rt   = 0;
    int exp_re   = 0;

    tx_sweep_ctrl #(
        .SETTLE_CYC (S),
        .DW         (DW),
        .CW         (CW),
        .TAP_MIN    (TMIN),
        .TAP_MAX    (TMAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .pat_mask    (pat_mask),
        .dwell_len   (dwell_len),
        .err_in      (err_in),
        .control     (control),
        .taps        (taps),
        .meas_en     (meas_en),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_pattern (res_pattern),
        .res_taps    (res_taps),
        .res_errs    (res_errs),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, ".control"}, int'(control), 0);
        check_eq({tag, ".taps"}, int'(taps), 0);
        check_eq({tag, ".meas_en"}, int'(meas_en), 0);
        check_eq({tag, ".busy"}, int'(busy), 0);
        check_eq({tag, ".res_valid"}, int'(res_valid), 0);
        check_eq({tag, ".res_pattern"}, int'(res_pattern), 0);
        check_eq({tag, ".res_taps"}, int'(res_taps), 0);
        check_eq({tag, ".res_errs"}, int'(res_errs), 0);
        check_eq({tag, ".done"}, int'(done), 0);
    endtask

    // mode: 0 err_in low, 1 err_in high, 2 random. abort_at: cycle after start to abort (0 none).
    task automatic run_sweep(input logic [1:0] mask, input int dwell, input int mode,
                             input int abort_at, input bit poke_start);
        int setp[$];
        int sett[$];
        int errq[$];
        int n, nd, per, total, last_c, k, off, sum, stop_c;
        int dut_rv, mod_rv, dut_dn, mod_dn;
        bit e_meas, e_rv, e_done, e_busy, e;
        for (int p = 0; p < 2; p++) begin
            if (mask[p]) begin
                for (int t = TMIN; t <= TMAX; t++) begin
                    setp.push_back(p);
                    sett.push_back(t);
                end
            end
        end
        n      = setp.size();
        nd     = (dwell == 0) ? 1 : dwell;
        per    = S + nd + 1;
        total  = (n == 0) ? 1 : n * per + 1;
        last_c = (abort_at > 0) ? abort_at + 3 : total + 3;
        stop_c = (abort_at > 0 && abort_at < total) ? abort_at : total;
        errq.push_back(0);
        dut_rv = 0; mod_rv = 0; dut_dn = 0; mod_dn = 0;

        pat_mask  = mask;
        dwell_len = DW'(dwell);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        pat_mask  = 2'($urandom);
        dwell_len = DW'($urandom);

        for (int c = 1; c <= last_c; c++) begin
            e_meas = 1'b0; e_rv = 1'b0; e_done = 1'b0; e_busy = 1'b0;
            if (abort_at > 0 && c > abort_at) begin
                // aborted: idle, settings held
            end else if (c <= n * per) begin
                k        = (c - 1) / per;
                off      = (c - 1) % per;
                exp_ctrl = setp[k];
                exp_taps = sett[k];
                e_busy   = 1'b1;
                e_meas   = (off >= S) && (off < S + nd);
                e_rv     = (off == per - 1);
                if (e_rv) begin
                    sum = 0;
                    for (int j = k * per + 1 + S; j <= k * per + S + nd; j++) sum += errq[j];
                    exp_rp = setp[k];
                    exp_rt = sett[k];
                    exp_re = (sum > MaxErr) ? MaxErr : sum;
                end
            end else if (c == total) begin
                e_done = 1'b1;
                e_busy = 1'b1;
            end
            check_eq("meas_en", int'(meas_en), int'(e_meas));
            check_eq("res_valid", int'(res_valid), int'(e_rv));
            check_eq("done", int'(done), int'(e_done));
            check_eq("busy", int'(busy), int'(e_busy));
            check_eq("control", int'(control), exp_ctrl);
            check_eq("taps", int'(taps), exp_taps & 7);
            check_eq("res_pattern", int'(res_pattern), exp_rp);
            check_eq("res_taps", int'(res_taps), exp_rt & 7);
            check_eq("res_errs", int'(res_errs), exp_re);
            dut_rv += int'(res_valid);
            mod_rv += int'(e_rv);
            dut_dn += int'(done);
            mod_dn += int'(e_done);

            e = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            errq.push_back(int'(e));
            err_in = e;
            abort  = (c == abort_at);
            start  = poke_start && (c % 9 == 4) && (c < stop_c);
            tick();
        end
        start  = 1'b0;
        abort  = 1'b0;
        err_in = 1'b0;
        check_eq("res_count", dut_rv, mod_rv);
        check_eq("done_count", dut_dn, mod_dn);
    endtask

    initial begin
        int per4;
        tick();
        check_zero_outputs("reset");
        reset = 1'b1;
        tick();
        check_zero_outputs("post_reset");

        run_sweep(2'b01, 4, 0, 0, 1'b0);
        run_sweep(2'b11, 10, 1, 0, 1'b0);
        run_sweep(2'b10, 0, 2, 0, 1'b0);
        run_sweep(2'b11, 0, 1, 0, 1'b0);

        per4 = S + 6 + 1;
        run_sweep(2'b11, 6, 2, 2 * per4 + S + 2, 1'b0);
        run_sweep(2'b10, 3, 2, 0, 1'b1);

        run_sweep(2'b00, 5, 0, 0, 1'b0);
        run_sweep(2'b01, 5, 2, 0, 1'b1);

        run_sweep(2'b01, 40, 1, 0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            run_sweep(2'($urandom), $urandom_range(0, 20), 2,
                      ($urandom_range(0, 1) != 0) ? $urandom_range(1, 80) : 0, 1'b1);
        end

        // Asynchronous reset in the middle of a measurement window.
        pat_mask  = 2'b11;
        dwell_len = DW'(20);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        for (int i = 0; i < S + 1; i++) tick();
        check_eq("mid_dwell.meas_en", int'(meas_en), 1);
        #2;
        reset = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_zero_outputs("after_async_reset");
        exp_ctrl = 0; exp_taps = 0; exp_rp = 0; exp_rt = 0; exp_re = 0;
        run_sweep(2'b01, 2, 2, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
